// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - op codes, sequencer states and memory-op classification
package pc_seq_pkg;

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BMN  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_BZ   = 3'd3;
    localparam logic [2:0] OP_JMOR = 3'd4;
    localparam logic [2:0] OP_JALM = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // BMN only goes to memory when the ALU result is negative
    function automatic logic is_mem_op(input logic [2:0] op, input logic n);
        return (op == OP_JMOR) || (op == OP_JALM) || ((op == OP_BMN) && n);
    endfunction

endpackage

// File: rtl/pc_wait_timer.sv
// rtl/pc_wait_timer.sv - saturating wait-state counter flagging the last allowed wait cycle
module pc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of wait cycles already completed
    assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered next-PC unit with memory-indirect jump handshake
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               ADDR_LSB = 2,
    parameter int               TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] reg_s,
    input  logic [WIDTH-1:0] j_diraddr,
    input  logic [15:0]      br_offset,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic             stall,
    output logic             link_we,
    output logic [WIDTH-1:0] link_data,
    output logic             fault
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(1) << ADDR_LSB;
    localparam logic [WIDTH-1:0] ALIGN_MASK = STEP - WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]       op_q, op_d;
    logic             link_we_q, link_we_d;
    logic [WIDTH-1:0] link_data_q, link_data_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] step, beq_tgt, target;
    logic             load, stall_c, tmr_clear, expired;

    assign step    = pc_q + STEP;
    assign beq_tgt = step + ({{(WIDTH-16){br_offset[15]}}, br_offset} << ADDR_LSB);

    pc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmr_clear),
        .en_i      (state_q == MEM_WAIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        op_d        = op_q;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        fault_d     = 1'b0;
        target      = step;
        load        = 1'b0;
        stall_c     = 1'b0;
        tmr_clear   = 1'b1;

        case (state_q)
            RUN: begin
                if (op_valid) begin
                    if (is_mem_op(op, alu_result[WIDTH-1])) begin
                        stall_c    = 1'b1;
                        mem_addr_d = alu_result;
                        op_d       = op;
                        state_d    = MEM_WAIT;
                    end else begin
                        load = 1'b1;
                        case (op)
                            OP_BRZ:  if (alu_zero) target = reg_s;
                            OP_BZ:   if (alu_zero) target = j_diraddr;
                            OP_BEQ:  if (alu_zero) target = beq_tgt;
                            OP_ILL:  fault_d = 1'b1;
                            default: target = step;
                        endcase
                    end
                end
            end
            MEM_WAIT: begin
                tmr_clear = 1'b0;
                stall_c   = 1'b1;
                // ack has priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    stall_c   = 1'b0;
                    load      = 1'b1;
                    target    = mem_rdata;
                    state_d   = RUN;
                    tmr_clear = 1'b1;
                    if (op_q == OP_JALM) begin
                        link_we_d   = 1'b1;
                        link_data_d = step;
                    end
                end else if (expired) begin
                    stall_c   = 1'b0;
                    load      = 1'b1;
                    fault_d   = 1'b1;
                    state_d   = RUN;
                    tmr_clear = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (load) begin
            pc_d = target & ~ALIGN_MASK;
            if ((target & ALIGN_MASK) != '0) fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            mem_addr_q  <= '0;
            op_q        <= OP_SEQ;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            op_q        <= op_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_req   = (state_q == MEM_WAIT);
    assign mem_addr  = mem_addr_q;
    assign pc        = pc_q;
    assign stall     = stall_c & rst_n;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a cycle model
module tb_pc_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op;
    logic        op_valid;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] reg_s;
    logic [31:0] j_diraddr;
    logic [15:0] br_offset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic        stall;
    logic        link_we;
    logic [31:0] link_data;
    logic        fault;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH    (32),
        .RESET_PC (32'h0),
        .ADDR_LSB (2),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .op_valid   (op_valid),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .reg_s      (reg_s),
        .j_diraddr  (j_diraddr),
        .br_offset  (br_offset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .stall      (stall),
        .link_we    (link_we),
        .link_data  (link_data),
        .fault      (fault)
    );

    int checks = 0;
    int errors = 0;

    // reference state: pc, whether a memory read is outstanding, which wait cycle we are in
    logic [31:0] m_pc, m_addr, m_ldata;
    bit          m_wait, m_jalm, m_lwe, m_fault;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] o, input logic [31:0] a, input bit z,
                         input logic [31:0] rs, input logic [31:0] jd, input logic [15:0] off,
                         input bit ack, input logic [31:0] rd);
        op_valid = v; op = o; alu_result = a; alu_zero = z;
        reg_s = rs; j_diraddr = jd; br_offset = off; mem_ack = ack; mem_rdata = rd;
    endtask

    task automatic idle();
        drive(0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0);
    endtask

    // one clock cycle: check outputs mid-cycle, predict the next state, advance past the edge
    task automatic step();
        logic [31:0] st, tgt, npc, naddr, nld;
        bit load, nf, nlwe, nwait, njalm, exp_stall;
        int ncnt;
        @(negedge clk);
        st = m_pc + 32'd4; tgt = st; load = 0; nf = 0; nlwe = 0; exp_stall = 0;
        nwait = m_wait; ncnt = m_cnt; naddr = m_addr; nld = m_ldata; njalm = m_jalm;
        if (!m_wait) begin
            if (op_valid) begin
                if (op == 3'd4 || op == 3'd5 || (op == 3'd1 && alu_result[31])) begin
                    exp_stall = 1; nwait = 1; ncnt = 1; naddr = alu_result; njalm = (op == 3'd5);
                end else begin
                    load = 1;
                    case (op)
                        3'd2: if (alu_zero) tgt = reg_s;
                        3'd3: if (alu_zero) tgt = j_diraddr;
                        3'd6: if (alu_zero) tgt = st + ({{16{br_offset[15]}}, br_offset} << 2);
                        3'd7: nf = 1;
                        default: ;
                    endcase
                end
            end
        end else if (mem_ack) begin
            load = 1; tgt = mem_rdata; nwait = 0;
            if (m_jalm) begin nlwe = 1; nld = st; end
        end else if (TO != 0 && m_cnt == TO) begin
            load = 1; nf = 1; nwait = 0;
        end else begin
            exp_stall = 1; ncnt = m_cnt + 1;
        end
        npc = m_pc;
        if (load) begin
            npc = tgt & ~32'h3;
            if (tgt[1:0] != 2'b00) nf = 1;
        end
        chk("pc", pc, m_pc);
        chk("mem_req", 32'(mem_req), 32'(m_wait));
        chk("mem_addr", mem_addr, m_addr);
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("link_we", 32'(link_we), 32'(m_lwe));
        chk("link_data", link_data, m_ldata);
        @(posedge clk);
        #1;
        m_pc = npc; m_wait = nwait; m_cnt = ncnt; m_addr = naddr; m_ldata = nld;
        m_jalm = njalm; m_lwe = nlwe; m_fault = nf;
    endtask

    task automatic do_reset();
        drive(1, 3'd4, 32'h0000_3000, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_link_we", 32'(link_we), 32'h0);
        chk("rst_link_data", link_data, 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        m_pc = 32'h0; m_wait = 0; m_cnt = 0; m_addr = 32'h0; m_ldata = 32'h0;
        m_jalm = 0; m_lwe = 0; m_fault = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #2;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd0, 32'h0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0);
            step();
            chk("seq_pc", pc, 32'(4 * (i + 1)));
        end
        do_reset();
        chk("midstream_reset_pc", pc, 32'h0);

        drive(1, 3'd3, 32'h0, 1, 32'h0, 32'h100, 16'h0, 0, 32'h0); step();
        drive(1, 3'd6, 32'h0, 1, 32'h0, 32'h0, 16'hFFFE, 0, 32'h0); step();
        chk("beq_taken", pc, 32'hFC);
        drive(1, 3'd3, 32'h0, 1, 32'h0, 32'h100, 16'h0, 0, 32'h0); step();
        drive(1, 3'd6, 32'h0, 0, 32'h0, 32'h0, 16'hFFFE, 0, 32'h0); step();
        chk("beq_not_taken", pc, 32'h104);

        drive(1, 3'd3, 32'h0, 1, 32'h0, 32'h40, 16'h0, 0, 32'h0); step();
        drive(1, 3'd5, 32'h2000, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0); step();
        idle(); step(); step();
        chk("jalm_addr", mem_addr, 32'h2000);
        drive(0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h800); step();
        idle();
        chk("jalm_pc", pc, 32'h800);
        chk("jalm_link_we", 32'(link_we), 32'h1);
        chk("jalm_link_data", link_data, 32'h44);
        step();

        drive(1, 3'd4, 32'h0000_5000, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0); step();
        idle();
        for (int i = 0; i < TO; i++) step();
        chk("timeout_pc", pc, 32'h804);
        chk("timeout_fault", 32'(fault), 32'h1);
        step();

        drive(1, 3'd4, 32'h0000_6000, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0); step();
        idle();
        for (int i = 0; i < TO - 1; i++) step();
        drive(0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h300); step();
        idle();
        chk("ack_at_timeout_pc", pc, 32'h300);
        chk("ack_at_timeout_fault", 32'(fault), 32'h0);

        drive(1, 3'd1, 32'h0000_1234, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0); step();
        chk("bmn_n0_pc", pc, 32'h304);
        chk("bmn_n0_req", 32'(mem_req), 32'h0);
        drive(1, 3'd2, 32'h0, 1, 32'h1006, 32'h0, 16'h0, 0, 32'h0); step();
        chk("brz_misaligned_pc", pc, 32'h1004);
        chk("brz_misaligned_fault", 32'(fault), 32'h1);
        drive(1, 3'd7, 32'h0, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0); step();
        chk("illegal_pc", pc, 32'h1008);
        chk("illegal_fault", 32'(fault), 32'h1);

        drive(1, 3'd4, 32'h0000_7000, 0, 32'h0, 32'h0, 16'h0, 0, 32'h0); step();
        idle(); step(); step();
        do_reset();
        chk("wait_reset_req", 32'(mem_req), 32'h0);
        chk("wait_reset_pc", pc, 32'h0);
        drive(0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 16'h0, 1, 32'h900); step();
        chk("stray_ack_pc", pc, 32'h0);

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) != 0) ? {1'b1, 31'($urandom)} : {1'b0, 31'($urandom)},
                  $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                  16'($urandom),
                  $urandom_range(0, 17) == 0,
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
